// File: rtl/fm_nco_pkg.sv
// Shared types and constant helpers for the multi-channel FM NCO.
// The quarter-sine table is built at elaboration with integer-only arithmetic.
package fm_nco_pkg;

  typedef enum logic [1:0] {
    CFG_FCW    = 2'd0,
    CFG_GAIN   = 2'd1,
    CFG_OFFSET = 2'd2,
    CFG_CTRL   = 2'd3
  } cfg_sel_e;

  typedef enum logic {
    MODE_FM = 1'b0,
    MODE_CW = 1'b1
  } mode_e;

  // pi/2 in Q30
  localparam longint HalfPiQ30 = 64'sd1686629713;

  // round((2^(amp_w-1)-1) * sin(pi/2 * (idx+0.5)/Q)), Taylor series in Q30 fixed point
  function automatic int quarter_sine(input int amp_w, input int lut_aw, input int idx);
    longint q, amp, x, x2, term, sum;
    q    = longint'(1) << (lut_aw - 2);
    amp  = (longint'(1) << (amp_w - 1)) - 1;
    x    = (longint'(2 * idx + 1) * HalfPiQ30) / (2 * q);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
      sum  = sum + term;
    end
    return int'((sum * amp + (longint'(1) << 29)) >>> 30);
  endfunction

endpackage

// File: rtl/fm_nco_multi_lut.sv
// Registered quarter-wave sine ROM with quadrant fold and negate.
// Two stages: table read, then sign/enable mux into a held output register.
module quarter_sine_lut
  import fm_nco_pkg::*;
#(
  parameter int unsigned LUT_AW = 8,
  parameter int unsigned AMP_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic              en_i,
  input  logic [LUT_AW-1:0] phase_i,
  output logic [AMP_W-1:0]  amp_o
);

  localparam int unsigned QAW = LUT_AW - 2;
  localparam int unsigned Q   = 1 << QAW;

  logic [AMP_W-1:0] rom [Q];

  for (genvar i = 0; i < Q; i++) begin : g_rom
    assign rom[i] = AMP_W'(quarter_sine(AMP_W, LUT_AW, i));
  end

  logic [QAW-1:0]   idx;
  logic [AMP_W-1:0] mag_q, mag_d, amp_q, amp_d;
  logic             neg_q, neg_d, en_q, en_d, vld_q, vld_d;

  always_comb begin
    // Odd quadrants read the table mirrored
    idx   = phase_i[LUT_AW-2] ? ~phase_i[QAW-1:0] : phase_i[QAW-1:0];
    mag_d = rom[idx];
    neg_d = phase_i[LUT_AW-1];
    en_d  = en_i;
    vld_d = valid_i;
    amp_d = amp_q;
    if (vld_q) begin
      if (!en_q)      amp_d = '0;
      else if (neg_q) amp_d = -mag_q;
      else            amp_d = mag_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mag_q <= '0;
      neg_q <= 1'b0;
      en_q  <= 1'b0;
      vld_q <= 1'b0;
      amp_q <= '0;
    end else begin
      mag_q <= mag_d;
      neg_q <= neg_d;
      en_q  <= en_d;
      vld_q <= vld_d;
      amp_q <= amp_d;
    end
  end

  assign amp_o = amp_q;

endmodule

// File: rtl/fm_nco_multi.sv
// Multi-channel FM NCO: per-channel config, audio-deviated phase accumulators and a
// fixed 3-cycle sample pipeline shared by all channels so outputs stay phase-aligned.
module fm_nco_multi
  import fm_nco_pkg::*;
#(
  parameter int unsigned      N_CH      = 2,
  parameter int unsigned      ACC_W     = 32,
  parameter int unsigned      AUDIO_W   = 16,
  parameter int unsigned      LUT_AW    = 8,
  parameter int unsigned      AMP_W     = 16,
  parameter int unsigned      DEV_SHIFT = 16,
  parameter logic [ACC_W-1:0] FCW_RESET = 32'h0400_0000,
  localparam int unsigned     CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    step_in,
  input  logic                    sync_in,
  input  logic [N_CH-1:0]         audio_valid_in,
  input  logic [N_CH*AUDIO_W-1:0] audio_in,
  input  logic                    cfg_we_in,
  input  logic [CH_W-1:0]         cfg_ch_in,
  input  logic [1:0]              cfg_sel_in,
  input  logic [ACC_W-1:0]        cfg_data_in,
  output logic [N_CH*AMP_W-1:0]   amp_out,
  output logic                    amp_valid_out
);

  localparam int unsigned DEV_W = ACC_W + AUDIO_W + 17;

  logic [ACC_W-1:0]   acc_q [N_CH], acc_d [N_CH], incr_q [N_CH], incr_d [N_CH];
  logic [ACC_W-1:0]   fcw_q [N_CH], fcw_d [N_CH], off_q [N_CH], off_d [N_CH];
  logic [AUDIO_W-1:0] audio_q [N_CH], audio_d [N_CH];
  logic [15:0]        gain_q [N_CH], gain_d [N_CH];
  mode_e              mode_q [N_CH], mode_d [N_CH];
  logic [LUT_AW-1:0]  phase_q [N_CH], phase_d [N_CH];
  logic [N_CH-1:0]    en_q, en_d, en0_q, en0_d, en1_q, en1_d;
  logic               v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, amp_valid_q, amp_valid_d;

  always_comb begin
    logic signed [DEV_W-1:0] dev;
    logic [ACC_W-1:0]        psum;
    dev         = '0;
    psum        = '0;
    en_d        = en_q;
    v0_d        = step_in;
    v1_d        = v0_q;
    v2_d        = v1_q;
    amp_valid_d = v2_q;
    en0_d       = en_q;
    en1_d       = en0_q;
    for (int c = 0; c < N_CH; c++) begin
      audio_d[c] = audio_q[c];
      fcw_d[c]   = fcw_q[c];
      gain_d[c]  = gain_q[c];
      off_d[c]   = off_q[c];
      mode_d[c]  = mode_q[c];
      if (audio_valid_in[c]) audio_d[c] = audio_in[c*AUDIO_W +: AUDIO_W];

      dev = DEV_W'($signed(audio_q[c])) * DEV_W'($signed({1'b0, gain_q[c]}));
      dev = dev >>> DEV_SHIFT;
      incr_d[c] = fcw_q[c] + ((mode_q[c] == MODE_CW) ? '0 : dev[ACC_W-1:0]);

      acc_d[c] = acc_q[c];
      if (sync_in)                acc_d[c] = '0;
      else if (step_in && en_q[c]) acc_d[c] = acc_q[c] + incr_q[c];

      psum       = acc_q[c] + off_q[c];
      phase_d[c] = psum[ACC_W-1 -: LUT_AW];

      // Channels beyond N_CH can never match, so their writes drop out here
      if (cfg_we_in && (CH_W'(c) == cfg_ch_in)) begin
        case (cfg_sel_e'(cfg_sel_in))
          CFG_FCW:    fcw_d[c]  = cfg_data_in;
          CFG_GAIN:   gain_d[c] = cfg_data_in[15:0];
          CFG_OFFSET: off_d[c]  = cfg_data_in;
          CFG_CTRL: begin
            en_d[c]   = cfg_data_in[0];
            mode_d[c] = mode_e'(cfg_data_in[1]);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int c = 0; c < N_CH; c++) begin
        acc_q[c]   <= '0;
        incr_q[c]  <= '0;
        fcw_q[c]   <= FCW_RESET;
        off_q[c]   <= '0;
        audio_q[c] <= '0;
        gain_q[c]  <= '0;
        mode_q[c]  <= MODE_FM;
        phase_q[c] <= '0;
      end
      en_q        <= '1;
      en0_q       <= '0;
      en1_q       <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      amp_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      incr_q      <= incr_d;
      fcw_q       <= fcw_d;
      off_q       <= off_d;
      audio_q     <= audio_d;
      gain_q      <= gain_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      en_q        <= en_d;
      en0_q       <= en0_d;
      en1_q       <= en1_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      amp_valid_q <= amp_valid_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    quarter_sine_lut #(
      .LUT_AW (LUT_AW),
      .AMP_W  (AMP_W)
    ) u_lut (
      .clk_i   (clk_in),
      .rst_ni  (rst_n_in),
      .valid_i (v1_q),
      .en_i    (en1_q[c]),
      .phase_i (phase_q[c]),
      .amp_o   (amp_out[c*AMP_W +: AMP_W])
    );
  end

  assign amp_valid_out = amp_valid_q;

endmodule

// File: tb/tb_fm_nco_multi.sv
// Self-checking bench for fm_nco_multi: per-feature tasks against a phase/sine model
// built from plain arithmetic and $sin, with a due-cycle queue for output samples.
module tb_fm_nco_multi;

  logic        clk = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        step_in = 1'b0, sync_in = 1'b0;
  logic [1:0]  audio_valid_in = '0;
  logic [31:0] audio_in = '0;
  logic        cfg_we_in = 1'b0;
  logic [0:0]  cfg_ch_in = '0;
  logic [1:0]  cfg_sel_in = '0;
  logic [31:0] cfg_data_in = '0;
  logic [31:0] amp_out;
  logic        amp_valid_out;

  fm_nco_multi dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n_in),
    .step_in        (step_in),
    .sync_in        (sync_in),
    .audio_valid_in (audio_valid_in),
    .audio_in       (audio_in),
    .cfg_we_in      (cfg_we_in),
    .cfg_ch_in      (cfg_ch_in),
    .cfg_sel_in     (cfg_sel_in),
    .cfg_data_in    (cfg_data_in),
    .amp_out        (amp_out),
    .amp_valid_out  (amp_valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] amp;
  } samp_t;

  logic [31:0]        acc_m [2], fcw_m [2], off_m [2];
  logic [15:0]        gain_m [2];
  logic signed [15:0] aud_m [2];
  logic               en_m [2], cw_m [2];
  samp_t              q [$];
  int                 cyc = 0;
  logic               exp_valid = 1'b0;
  logic [31:0]        exp_amp = '0;
  int                 total = 0, bad = 0;

  function automatic logic [31:0] incr_of(input int c);
    longint d;
    d = (longint'(aud_m[c]) * longint'(gain_m[c])) >>> 16;
    return cw_m[c] ? fcw_m[c] : fcw_m[c] + 32'(d);
  endfunction

  function automatic logic [15:0] sine_ref(input logic [7:0] p);
    real x;
    int  r;
    x = 32767.0 * $sin(2.0 * 3.141592653589793 * (real'(p) + 0.5) / 256.0);
    if (x < 0.0) r = -$rtoi(-x + 0.5);
    else         r = $rtoi(x + 0.5);
    return 16'(r);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      acc_m[c] = '0; fcw_m[c] = 32'h0400_0000; off_m[c] = '0;
      gain_m[c] = '0; aud_m[c] = '0; en_m[c] = 1'b1; cw_m[c] = 1'b0;
    end
    q.delete();
    exp_amp   = '0;
    exp_valid = 1'b0;
  endtask

  // Called just after the edge the current inputs were presented to
  task automatic model_edge();
    samp_t       s;
    logic [31:0] ph;
    exp_valid = 1'b0;
    if (!rst_n_in) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 2; c++) begin
      if (sync_in)                acc_m[c] = '0;
      else if (step_in && en_m[c]) acc_m[c] = acc_m[c] + incr_of(c);
    end
    if (step_in) begin
      for (int c = 0; c < 2; c++) begin
        ph = acc_m[c] + off_m[c];
        s.amp[c*16 +: 16] = en_m[c] ? sine_ref(ph[31:24]) : 16'h0;
      end
      s.due = cyc + 3;
      q.push_back(s);
    end
    if (cfg_we_in) begin
      case (cfg_sel_in)
        2'd0: fcw_m[cfg_ch_in] = cfg_data_in;
        2'd1: gain_m[cfg_ch_in] = cfg_data_in[15:0];
        2'd2: off_m[cfg_ch_in] = cfg_data_in;
        default: begin
          en_m[cfg_ch_in] = cfg_data_in[0];
          cw_m[cfg_ch_in] = cfg_data_in[1];
        end
      endcase
    end
    for (int c = 0; c < 2; c++) if (audio_valid_in[c]) aud_m[c] = audio_in[c*16 +: 16];
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_valid = 1'b1;
      exp_amp   = q[0].amp;
      void'(q.pop_front());
    end
  endtask

  task automatic advance(input logic st, input logic sy);
    step_in = st;
    sync_in = sy;
    @(negedge clk);
    cyc++;
    model_edge();
    step_in = 1'b0; sync_in = 1'b0; cfg_we_in = 1'b0; audio_valid_in = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) advance(1'b0, 1'b0);
  endtask

  task automatic cfg_write(input int c, input logic [1:0] sel, input logic [31:0] data);
    cfg_we_in = 1'b1; cfg_ch_in = 1'(c); cfg_sel_in = sel; cfg_data_in = data;
    advance(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    idle(3);
    rst_n_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance(1'b0, 1'b0);
      total++;
      if (amp_valid_out !== 1'b0 || amp_out !== 32'h0) begin
        bad++;
        $display("FAIL reset cyc=%0d got v=%b amp=%h want v=0 amp=0", cyc, amp_valid_out, amp_out);
      end
    end
    for (int c = 0; c < 2; c++) begin
      total++;
      if (dut.acc_q[c] !== 32'h0) begin
        bad++;
        $display("FAIL reset_acc ch%0d got %h want 0", c, dut.acc_q[c]);
      end
    end
  endtask

  task automatic test_first_run();
    bit seen = 1'b0;
    for (int i = 0; i < 72; i++) begin
      advance(i < 68, 1'b0);
      total++;
      if (amp_valid_out !== exp_valid || amp_out !== exp_amp) begin
        bad++;
        $display("FAIL first_run cyc=%0d got v=%b amp=%h want v=%b amp=%h",
                 cyc, amp_valid_out, amp_out, exp_valid, exp_amp);
      end
      if (exp_valid && !seen) begin
        seen = 1'b1;
        total++;
        if (amp_out[15:0] !== 16'd3612) begin
          bad++;
          $display("FAIL first_sample got %0d want 3612", $signed(amp_out[15:0]));
        end
      end
    end
  endtask

  task automatic test_offset_mirror();
    cfg_write(1, 2'd2, 32'h8000_0000);
    idle(2);
    for (int i = 0; i < 74; i++) begin
      advance(i < 70, 1'b0);
      total++;
      if (amp_valid_out !== exp_valid || amp_out !== exp_amp) begin
        bad++;
        $display("FAIL offset_mirror cyc=%0d got v=%b amp=%h want v=%b amp=%h",
                 cyc, amp_valid_out, amp_out, exp_valid, exp_amp);
      end
      if (amp_valid_out) begin
        total++;
        if (amp_out[15:0] === 16'h8000 || amp_out[31:16] === 16'h8000) begin
          bad++;
          $display("FAIL no_min_code cyc=%0d got amp=%h want neither half 8000", cyc, amp_out);
        end
      end
    end
  endtask

  task automatic test_deviation();
    cfg_write(0, 2'd1, 32'h8000);
    cfg_write(1, 2'd1, 32'h8000);
    audio_in = {16'h8000, 16'h7FFF};
    audio_valid_in = 2'b11;
    advance(1'b0, 1'b1);
    idle(3);
    for (int i = 0; i < 8; i++) begin
      advance(i < 4, 1'b0);
      total++;
      if (amp_valid_out !== exp_valid || amp_out !== exp_amp) begin
        bad++;
        $display("FAIL deviation cyc=%0d got v=%b amp=%h want v=%b amp=%h",
                 cyc, amp_valid_out, amp_out, exp_valid, exp_amp);
      end
    end
    total += 2;
    if (dut.acc_q[0] !== 32'h1000_FFFC) begin
      bad++;
      $display("FAIL dev_acc_pos got %h want 1000fffc", dut.acc_q[0]);
    end
    if (dut.acc_q[1] !== 32'h0FFF_0000) begin
      bad++;
      $display("FAIL dev_acc_neg got %h want 0fff0000", dut.acc_q[1]);
    end
  endtask

  task automatic test_cw_fcw();
    cfg_write(0, 2'd3, 32'h3);
    cfg_write(1, 2'd3, 32'h3);
    audio_in = {16'h8001, 16'h7FFF};
    audio_valid_in = 2'b11;
    advance(1'b0, 1'b1);
    idle(3);
    for (int i = 0; i < 9; i++) begin
      advance(i < 5, 1'b0);
      total++;
      if (amp_valid_out !== exp_valid || amp_out !== exp_amp) begin
        bad++;
        $display("FAIL cw_run cyc=%0d got v=%b amp=%h want v=%b amp=%h",
                 cyc, amp_valid_out, amp_out, exp_valid, exp_amp);
      end
    end
    for (int c = 0; c < 2; c++) begin
      total++;
      if (dut.acc_q[c] !== 32'h1400_0000) begin
        bad++;
        $display("FAIL cw_acc ch%0d got %h want 14000000", c, dut.acc_q[c]);
      end
    end
    cfg_write(0, 2'd0, 32'h0100_0000);
    idle(2);
    for (int i = 0; i < 7; i++) begin
      advance(i < 3, 1'b0);
      total++;
      if (amp_valid_out !== exp_valid || amp_out !== exp_amp) begin
        bad++;
        $display("FAIL fcw_change cyc=%0d got v=%b amp=%h want v=%b amp=%h",
                 cyc, amp_valid_out, amp_out, exp_valid, exp_amp);
      end
    end
    total += 2;
    if (dut.acc_q[0] !== 32'h1700_0000) begin
      bad++;
      $display("FAIL fcw_cont ch0 got %h want 17000000", dut.acc_q[0]);
    end
    if (dut.acc_q[1] !== 32'h2000_0000) begin
      bad++;
      $display("FAIL fcw_cont ch1 got %h want 20000000", dut.acc_q[1]);
    end
  endtask

  task automatic test_sync_disable();
    bit seen = 1'b0;
    cfg_write(0, 2'd3, 32'h1);
    cfg_write(0, 2'd1, 32'h0);
    cfg_write(1, 2'd3, 32'h0);
    idle(3);
    for (int i = 0; i < 8; i++) begin
      advance(i < 4, i == 0);
      total++;
      if (amp_valid_out !== exp_valid || amp_out !== exp_amp) begin
        bad++;
        $display("FAIL sync_disable cyc=%0d got v=%b amp=%h want v=%b amp=%h",
                 cyc, amp_valid_out, amp_out, exp_valid, exp_amp);
      end
      if (exp_valid && !seen) begin
        seen = 1'b1;
        total++;
        if (amp_out !== {16'h0, 16'd402}) begin
          bad++;
          $display("FAIL sync_sample got %h want 00000192", amp_out);
        end
      end
    end
    total += 2;
    if (dut.acc_q[0] !== 32'h0300_0000) begin
      bad++;
      $display("FAIL sync_acc ch0 got %h want 03000000", dut.acc_q[0]);
    end
    if (dut.acc_q[1] !== 32'h0) begin
      bad++;
      $display("FAIL disabled_hold ch1 got %h want 0", dut.acc_q[1]);
    end
  endtask

  task automatic test_random();
    logic st, sy;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 2; c++) begin
        cfg_write(c, 2'd0, $urandom);
        cfg_write(c, 2'd1, 32'($urandom_range(0, 65535)));
        cfg_write(c, 2'd2, $urandom);
        cfg_write(c, 2'd3, {30'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
      end
      audio_in = $urandom;
      audio_valid_in = 2'b11;
      advance(1'b0, 1'b0);
      idle(3);
      for (int i = 0; i < 28; i++) begin
        st = (i < 24) && ($urandom_range(0, 1) == 1);
        sy = (i < 24) && ($urandom_range(0, 15) == 0);
        advance(st, sy);
        total++;
        if (amp_valid_out !== exp_valid || amp_out !== exp_amp) begin
          bad++;
          $display("FAIL random r=%0d cyc=%0d got v=%b amp=%h want v=%b amp=%h",
                   r, cyc, amp_valid_out, amp_out, exp_valid, exp_amp);
        end
      end
      for (int c = 0; c < 2; c++) begin
        total++;
        if (dut.acc_q[c] !== acc_m[c]) begin
          bad++;
          $display("FAIL random_acc r=%0d ch%0d got %h want %h", r, c, dut.acc_q[c], acc_m[c]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      advance(1'b1, 1'b0);
      total++;
      if (amp_valid_out !== exp_valid || amp_out !== exp_amp) begin
        bad++;
        $display("FAIL pre_reset cyc=%0d got v=%b amp=%h want v=%b amp=%h",
                 cyc, amp_valid_out, amp_out, exp_valid, exp_amp);
      end
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    total++;
    if (amp_valid_out !== 1'b0 || amp_out !== 32'h0) begin
      bad++;
      $display("FAIL async_reset got v=%b amp=%h want v=0 amp=0", amp_valid_out, amp_out);
    end
    model_reset();
    idle(2);
    rst_n_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      advance(i == 6, 1'b0);
      total++;
      if (amp_valid_out !== exp_valid || amp_out !== exp_amp) begin
        bad++;
        $display("FAIL post_reset cyc=%0d got v=%b amp=%h want v=%b amp=%h",
                 cyc, amp_valid_out, amp_out, exp_valid, exp_amp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_run();
    test_offset_mirror();
    test_deviation();
    test_cw_fcw();
    test_sync_disable();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
